hsid_x_band_unpacker: RTL and testbench

- Sits directly downstream of the OBI memory reader.
- Takes its un-throttled word stream (valid only, no backpressure) into a small FIFO.
- Splits each WORD_WIDTH word into WORD_WIDTH/DATA_WIDTH band samples and presents them on a valid/ready stream to the distance datapath.
- Counts bands per pixel and flags the last one.

---
 rtl/hsid_x_band_unpacker_if.sv | 31 +++
 rtl/hsid_x_band_unpacker.sv | 158 +++++++++++++++
 tb/tb_hsid_x_band_unpacker.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hsid_x_band_unpacker_if.sv
// Word-in / band-out stream bundle for the band unpacker.
// slave = unpacker side, master = memory reader + consumer side.
interface hsid_x_band_unpacker_if #(
    parameter int WORD_WIDTH = 32,
    parameter int DATA_WIDTH = 16
);
    logic                  data_in_valid;
    logic [WORD_WIDTH-1:0] data_in;
    logic                  band_valid;
    logic [DATA_WIDTH-1:0] band_data;
    logic                  band_last;
    logic                  band_ready;

    modport master (
        output data_in_valid,
        output data_in,
        output band_ready,
        input  band_valid,
        input  band_data,
        input  band_last
    );

    modport slave (
        input  data_in_valid,
        input  data_in,
        input  band_ready,
        output band_valid,
        output band_data,
        output band_last
    );
endinterface

// File: rtl/hsid_x_band_unpacker.sv
// Word FIFO + band splitter with per-pixel band counting.
// Define HSID_X_BAND_UNPACKER_SWAP_EN to emit samples MSB-first.
module hsid_x_band_unpacker #(
    parameter int WORD_WIDTH     = 32,
    parameter int DATA_WIDTH     = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int BAND_CNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      clear,
    input  logic [BAND_CNT_WIDTH-1:0] num_bands,
    hsid_x_band_unpacker_if.slave     bus,
    output logic                      idle,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow
);
    localparam int SPW = WORD_WIDTH / DATA_WIDTH;
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int SW  = (SPW > 1) ? $clog2(SPW) : 1;

    localparam logic [SW-1:0]             SUB_LAST = SW'(SPW - 1);
    localparam logic [SW-1:0]             SUB_ONE  = SW'(1);
    localparam logic [AW:0]               PTR_ONE  = (AW + 1)'(1);
    localparam logic [BAND_CNT_WIDTH-1:0] CNT_ONE  = BAND_CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                    state;
    logic [WORD_WIDTH-1:0]     mem [FIFO_DEPTH];
    logic [AW:0]               wr_ptr;
    logic [AW:0]               rd_ptr;
    logic [BAND_CNT_WIDTH-1:0] band_cnt;
    logic [BAND_CNT_WIDTH-1:0] limit;
    logic [SW-1:0]             sub_idx;

    logic                  run;
    logic                  empty;
    logic                  full;
    logic                  xfer;
    logic                  last;
    logic                  pop;
    logic                  push;
    logic                  ovf_hit;
    logic [WORD_WIDTH-1:0] head;
    logic [SW-1:0]         sel;
    logic [DATA_WIDTH-1:0] sample;

    assign run   = (state == S_RUN);
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign bus.band_valid = run && !empty;
    assign last    = bus.band_valid && (band_cnt == limit - CNT_ONE);
    assign xfer    = bus.band_valid && bus.band_ready;
    assign pop     = xfer && ((sub_idx == SUB_LAST) || last);
    assign push    = run && bus.data_in_valid && (!full || pop);
    assign ovf_hit = run && bus.data_in_valid && full && !pop;

    assign bus.band_last = last;
    assign head          = mem[rd_ptr[AW-1:0]];

`ifdef HSID_X_BAND_UNPACKER_SWAP_EN
    assign sel = SUB_LAST - sub_idx;
`else
    assign sel = sub_idx;
`endif

    assign sample        = head[int'(sel) * DATA_WIDTH +: DATA_WIDTH];
    assign bus.band_data = bus.band_valid ? sample : '0;

    // Store accepted words at the write slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !clear) begin
            mem[wr_ptr[AW-1:0]] <= bus.data_in;
        end
    end

    // Pixel sequencing, FIFO pointers, band counting and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            band_cnt <= '0;
            sub_idx  <= '0;
            limit    <= CNT_ONE;
            idle     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else if (clear) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            band_cnt <= '0;
            sub_idx  <= '0;
            idle     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_RUN;
                        limit    <= (num_bands == '0) ? CNT_ONE : num_bands;
                        wr_ptr   <= '0;
                        rd_ptr   <= '0;
                        band_cnt <= '0;
                        sub_idx  <= '0;
                        overflow <= 1'b0;
                        idle     <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (push) wr_ptr <= wr_ptr + PTR_ONE;
                    if (pop) rd_ptr <= rd_ptr + PTR_ONE;
                    if (ovf_hit) overflow <= 1'b1;
                    if (xfer) begin
                        band_cnt <= band_cnt + CNT_ONE;
                        sub_idx  <= (sub_idx == SUB_LAST) ? '0 : sub_idx + SUB_ONE;
                    end
                    if (xfer && last) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    done   <= 1'b0;
                    idle   <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    idle  <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hsid_x_band_unpacker.sv
// Bench for hsid_x_band_unpacker: directed cases plus random traffic,
// checked every cycle against a queue-based pixel model.
module tb_hsid_x_band_unpacker;
    localparam int WW    = 32;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 8;
    localparam int SPW   = WW / DW;

    localparam int PH_IDLE = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_DONE = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          clear;
    logic [CW-1:0] num_bands;
    logic          idle;
    logic          busy;
    logic          done;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] got[$];
    logic          got_last[$];

    logic [WW-1:0] mq[$];
    int            m_ph;
    int            m_cnt;
    int            m_lim;
    logic          m_ovf;

    hsid_x_band_unpacker_if #(.WORD_WIDTH(WW), .DATA_WIDTH(DW)) bus ();

    hsid_x_band_unpacker #(
        .WORD_WIDTH    (WW),
        .DATA_WIDTH    (DW),
        .FIFO_DEPTH    (DEPTH),
        .BAND_CNT_WIDTH(CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .clear    (clear),
        .num_bands(num_bands),
        .bus      (bus.slave),
        .idle     (idle),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [WW-1:0] w(int k);
        return {16'(2 * k + 2), 16'(2 * k + 1)};
    endfunction

    // Value of the i-th band across consecutive words w(0), w(1), ...
    function automatic logic [31:0] exp_seq(int i);
`ifdef HSID_X_BAND_UNPACKER_SWAP_EN
        return 32'((i ^ 1) + 1);
`else
        return 32'(i + 1);
`endif
    endfunction

    function automatic logic m_valid();
        return (m_ph == PH_RUN) && (mq.size() > 0);
    endfunction

    function automatic logic [DW-1:0] m_sample();
        int            pos;
        logic [WW-1:0] hw;
        pos = m_cnt % SPW;
`ifdef HSID_X_BAND_UNPACKER_SWAP_EN
        pos = SPW - 1 - pos;
`endif
        hw = mq[0];
        return hw[pos*DW +: DW];
    endfunction

    // Reference pixel model, advanced on each clock edge
    always @(posedge clk or negedge rst_n) begin
        logic xf;
        logic fin;
        if (!rst_n) begin
            m_ph  = PH_IDLE;
            mq.delete();
            m_cnt = 0;
            m_lim = 1;
            m_ovf = 1'b0;
        end else if (clear) begin
            m_ph  = PH_IDLE;
            mq.delete();
            m_cnt = 0;
            m_ovf = 1'b0;
        end else begin
            case (m_ph)
                PH_IDLE: begin
                    if (start) begin
                        m_ph  = PH_RUN;
                        m_lim = (num_bands == 0) ? 1 : int'(num_bands);
                        mq.delete();
                        m_cnt = 0;
                        m_ovf = 1'b0;
                    end
                end
                PH_RUN: begin
                    xf  = m_valid() && bus.band_ready;
                    fin = xf && (m_cnt == m_lim - 1);
                    if (xf) begin
                        if (fin || (m_cnt % SPW) == SPW - 1)
                            void'(mq.pop_front());
                        m_cnt++;
                    end
                    if (bus.data_in_valid) begin
                        if (mq.size() < DEPTH) mq.push_back(bus.data_in);
                        else m_ovf = 1'b1;
                    end
                    if (fin) m_ph = PH_DONE;
                end
                default: begin
                    m_ph = PH_IDLE;
                    mq.delete();
                end
            endcase
        end
    end

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        logic          ev;
        logic [DW-1:0] ed;
        logic          el;
        ev = m_valid();
        ed = ev ? m_sample() : '0;
        el = ev && (m_cnt == m_lim - 1);
        chk("band_valid", 32'(bus.band_valid), 32'(ev));
        chk("band_data", 32'(bus.band_data), 32'(ed));
        chk("band_last", 32'(bus.band_last), 32'(el));
        chk("idle", 32'(idle), 32'(m_ph == PH_IDLE));
        chk("busy", 32'(busy), 32'(m_ph == PH_RUN));
        chk("done", 32'(done), 32'(m_ph == PH_DONE));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (bus.band_valid === 1'b1 && bus.band_ready === 1'b1) begin
            got.push_back(bus.band_data);
            got_last.push_back(bus.band_last);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_px(input int n);
        got.delete();
        got_last.delete();
        start     = 1'b1;
        num_bands = CW'(n);
        cyc();
        start = 1'b0;
    endtask

    task automatic push_words(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            bus.data_in_valid = 1'b1;
            bus.data_in       = w(first + i);
            cyc();
        end
        bus.data_in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (idle !== 1'b1 && n < budget) begin
            cyc();
            n++;
        end
        chk("idle_reached", 32'(idle), 32'd1);
    endtask

    initial begin
        rst_n             = 1'b0;
        start             = 1'b0;
        clear             = 1'b0;
        num_bands         = '0;
        bus.data_in_valid = 1'b0;
        bus.data_in       = '0;
        bus.band_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_valid", 32'(bus.band_valid), 32'd0);
        chk("rst_data", 32'(bus.band_data), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        // Four bands over two words
        bus.band_ready = 1'b1;
        start_px(4);
        push_words(0, 2);
        wait_idle(20);
        chk("t1_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            chk("t1_data", 32'(got[i]), exp_seq(i));
        if (got.size() == 4) begin
            chk("t1_last3", 32'(got_last[3]), 32'd1);
            chk("t1_last2", 32'(got_last[2]), 32'd0);
        end

        // Three bands: upper half of word 2 dropped
        start_px(3);
        push_words(0, 2);
        wait_idle(20);
        chk("t2_count", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3 && i < got.size(); i++)
            chk("t2_data", 32'(got[i]), exp_seq(i));
        if (got.size() == 3) chk("t2_last", 32'(got_last[2]), 32'd1);

        // Overflow with stalled consumer
        bus.band_ready = 1'b0;
        start_px(16);
        push_words(0, 5);
        cyc();
        chk("t3_ovf", 32'(overflow), 32'd1);
        chk("t3_valid", 32'(bus.band_valid), 32'd1);
        chk("t3_data", 32'(bus.band_data), exp_seq(0));
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("t3_clr_ovf", 32'(overflow), 32'd0);

        // Full FIFO accepts a word on a popping cycle
        start_px(16);
        push_words(0, 4);
        bus.band_ready = 1'b1;
        cyc();
        push_words(4, 1);
        chk("t4_ovf", 32'(overflow), 32'd0);
        repeat (6) cyc();
        push_words(5, 3);
        wait_idle(40);
        chk("t4_count", 32'(got.size()), 32'd16);
        for (int i = 0; i < 16 && i < got.size(); i++)
            chk("t4_data", 32'(got[i]), exp_seq(i));
        chk("t4_ovf_end", 32'(overflow), 32'd0);

        // Mid-pixel clear then a fresh pixel
        bus.band_ready = 1'b0;
        start_px(8);
        push_words(0, 4);
        bus.band_ready = 1'b1;
        cyc();
        cyc();
        bus.band_ready = 1'b0;
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("t5_idle", 32'(idle), 32'd1);
        chk("t5_valid", 32'(bus.band_valid), 32'd0);
        chk("t5_ovf", 32'(overflow), 32'd0);
        chk("t5_sent", 32'(got.size()), 32'd2);
        start_px(2);
        bus.data_in_valid = 1'b1;
        bus.data_in       = 32'h00BB_00AA;
        cyc();
        bus.data_in_valid = 1'b0;
        bus.band_ready    = 1'b1;
        wait_idle(20);
        chk("t5_count", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
`ifdef HSID_X_BAND_UNPACKER_SWAP_EN
            chk("t5_d0", 32'(got[0]), 32'h00BB);
            chk("t5_d1", 32'(got[1]), 32'h00AA);
`else
            chk("t5_d0", 32'(got[0]), 32'h00AA);
            chk("t5_d1", 32'(got[1]), 32'h00BB);
`endif
        end

        // Zero bands behaves as one
        start_px(0);
        push_words(0, 1);
        wait_idle(20);
        chk("t6_count", 32'(got.size()), 32'd1);
        if (got.size() == 1) begin
            chk("t6_data", 32'(got[0]), exp_seq(0));
            chk("t6_last", 32'(got_last[0]), 32'd1);
        end

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            start             = ($urandom_range(3) == 0);
            num_bands         = CW'($urandom_range(12));
            clear             = ($urandom_range(79) == 0);
            bus.data_in_valid = 1'($urandom_range(1));
            bus.data_in       = $urandom;
            bus.band_ready    = ($urandom_range(3) != 0);
            cyc();
        end
        start             = 1'b0;
        clear             = 1'b0;
        bus.data_in_valid = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
